// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
//   Shared definitions for the HI/LO multiply/divide unit:
//   default operand width, operation encodings, FSM state encodings
//   and small helpers for decoding the operation.
package mul_div_unit_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Bundle between the EX stage and the multiply/divide unit.
//   Start/Op/inA/inB   : launch an operation (operands from forwarding muxes)
//   MthiWrite/MtloWrite/WriteData : MTHI/MTLO moves
//   Busy/Done/Hi/Lo    : status and HI/LO register contents
//   master = EX stage / hazard side, slave = the unit itself.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             MthiWrite;
  logic             MtloWrite;
  logic [WIDTH-1:0] WriteData;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, inA, inB, MthiWrite, MtloWrite, WriteData,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, inA, inB, MthiWrite, MtloWrite, WriteData,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/mul_div_unit_core.sv
// muldiv_iter_core
//   Unsigned iterative datapath: one shift-add multiply step or one
//   restoring shift-subtract divide step per 'step' cycle.
//   clk/rst : clock, synchronous active-high reset (counter only)
//   load    : capture magnitudes a/b and clear partial state
//   step    : perform one iteration
//   is_div  : operation type, captured on load
//   prod    : 2*WIDTH product accumulator
//   quo/rem : quotient / remainder
//   last    : the current step is the final (WIDTH-th) one
module muldiv_iter_core
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem,
  output logic               last
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               unused_rem_msb;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    // Multiply: add the multiplicand into the upper half when the LSB of the
    // multiplier (held in the lower half) is set, then shift right by one.
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
    // Divide: bring the next dividend bit into the remainder and trial-subtract;
    // bit WIDTH of the difference is the borrow.
    shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, b_q};
    if (load) begin
      cnt_d    = '0;
      acc_d    = {{WIDTH{1'b0}}, a};
      rem_d    = '0;
      quo_d    = a;
      b_d      = b;
      is_div_d = is_div;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div_q) begin
        if (diff[WIDTH]) begin
          rem_d = shifted;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
          rem_d = diff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    rem_q    <= rem_d;
    quo_q    <= quo_d;
    b_q      <= b_d;
    is_div_q <= is_div_d;
  end

  // The restored remainder never exceeds the divisor, so its top bit is zero.
  assign unused_rem_msb = rem_q[WIDTH];

  assign prod = acc_q;
  assign quo  = quo_q;
  assign rem  = rem_q[WIDTH-1:0];
  assign last = (cnt_q == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   MIPS HI/LO multiply/divide unit for the EX stage. Captures operand
//   signs and magnitudes, runs the unsigned iterative core for WIDTH
//   cycles, applies sign correction and writes HI/LO. Also handles
//   MTHI/MTLO moves while idle.
//   Clk   : clock
//   Reset : synchronous active-high reset
//   bus   : mul_div_unit_if slave (Start/Op/inA/inB, moves, Busy/Done/Hi/Lo)
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic Clk,
  input  logic Reset,
  mul_div_unit_if.slave bus
);
  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               busy;
  logic               start_ok;
  op_e                op_in;
  logic               in_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] core_prod, prod_fix;
  logic [WIDTH-1:0]   core_quo, core_rem;
  logic               core_last;
  logic               neg_res;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_in     = op_e'(bus.Op);
  assign in_signed = op_is_signed(op_in);
  assign start_ok  = (state_q == ST_IDLE) && bus.Start;
  assign mag_a     = mag(bus.inA, in_signed & bus.inA[WIDTH-1]);
  assign mag_b     = mag(bus.inB, in_signed & bus.inB[WIDTH-1]);

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (Clk),
    .rst    (Reset),
    .load   (start_ok),
    .step   (state_q == ST_RUN),
    .is_div (op_is_div(op_in)),
    .a      (mag_a),
    .b      (mag_b),
    .prod   (core_prod),
    .quo    (core_quo),
    .rem    (core_rem),
    .last   (core_last)
  );

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.Start) state_d = ST_RUN;
      ST_RUN:  if (core_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Operand capture, sign fix-up and HI/LO update
  always_comb begin
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    neg_res  = sign_a_q ^ sign_b_q;
    prod_fix = neg_res ? -core_prod : core_prod;
    if (start_ok) begin
      // A move on the same edge as Start is dropped.
      is_div_d = op_is_div(op_in);
      sign_a_d = in_signed & bus.inA[WIDTH-1];
      sign_b_d = in_signed & bus.inB[WIDTH-1];
      div0_d   = (bus.inB == '0);
    end else if (state_q == ST_IDLE) begin
      if (bus.MthiWrite) hi_d = bus.WriteData;
      if (bus.MtloWrite) lo_d = bus.WriteData;
    end else if (state_q == ST_FIX) begin
      done_d = 1'b1;
      if (is_div_q) begin
        // With a zero divisor the core leaves |inA| as remainder, so the
        // dividend-sign fix-up alone restores Hi = inA.
        lo_d = div0_q ? '1 : (neg_res ? -core_quo : core_quo);
        hi_d = sign_a_q ? -core_rem : core_rem;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge Clk) begin
    is_div_q <= is_div_d;
    sign_a_q <= sign_a_d;
    sign_b_q <= sign_b_d;
    div0_q   <= div0_d;
  end

  assign bus.Busy = busy;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed-vector bench for mul_div_unit with hand-computed results.
module tb_mul_div_unit;
  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic do_move(input logic hw, input logic lw, input logic [31:0] data);
    bus.MthiWrite = hw;
    bus.MtloWrite = lw;
    bus.WriteData = data;
    @(posedge Clk);
    #1;
    bus.MthiWrite = 1'b0;
    bus.MtloWrite = 1'b0;
  endtask

  // Launch an operation, wait for Done (bounded), check latency, hold
  // behaviour of Hi/Lo during the run, Busy, and the final result.
  task automatic do_op(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input bit mtlo_at_start, input int inject_at);
    logic [31:0] h0, l0;
    int          lat;
    bit          hold_bad;
    h0 = bus.Hi;
    l0 = bus.Lo;
    lat = -1;
    hold_bad = 1'b0;
    bus.Op        = op;
    bus.inA       = a;
    bus.inB       = b;
    bus.Start     = 1'b1;
    bus.MtloWrite = mtlo_at_start;
    bus.WriteData = 32'hAAAA5555;
    @(posedge Clk);
    #1;
    bus.Start     = 1'b0;
    bus.MtloWrite = 1'b0;
    bus.inA       = 32'h0BAD0BAD;
    bus.inB       = 32'h00000003;
    bus.Op        = 2'b11;
    chk({tag, " busy after start"}, 64'(bus.Busy), 64'd1);
    if (mtlo_at_start) chk({tag, " lo not moved"}, 64'(bus.Lo), 64'(l0));
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      if (n == inject_at) begin
        bus.Start     = 1'b1;
        bus.Op        = 2'b10;
        bus.inA       = 32'd100;
        bus.inB       = 32'd7;
        bus.MthiWrite = 1'b1;
        bus.WriteData = 32'h0000DEAD;
      end
      @(posedge Clk);
      #1;
      bus.Start     = 1'b0;
      bus.MthiWrite = 1'b0;
      if (bus.Done) lat = n;
      else if (n < 33) begin
        if (bus.Hi !== h0 || bus.Lo !== l0 || bus.Busy !== 1'b1) hold_bad = 1'b1;
      end
    end
    chk({tag, " latency"}, 64'(lat), 64'd33);
    chk({tag, " hold during run"}, 64'(hold_bad), 64'd0);
    chk({tag, " busy at done"}, 64'(bus.Busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.Hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(bus.Lo), 64'(exp_lo));
    @(posedge Clk);
    #1;
    chk({tag, " done pulse"}, 64'(bus.Done), 64'd0);
  endtask

  initial begin
    bit seen_done;
    Reset         = 1'b1;
    bus.Start     = 1'b0;
    bus.Op        = 2'b00;
    bus.inA       = '0;
    bus.inB       = '0;
    bus.MthiWrite = 1'b0;
    bus.MtloWrite = 1'b0;
    bus.WriteData = '0;
    @(posedge Clk);
    #1;
    do_reset();
    do_move(1'b1, 1'b1, 32'hFFFF0000);
    do_reset();
    chk("reset hi",   64'(bus.Hi),   64'd0);
    chk("reset lo",   64'(bus.Lo),   64'd0);
    chk("reset busy", 64'(bus.Busy), 64'd0);
    chk("reset done", 64'(bus.Done), 64'd0);

    do_move(1'b1, 1'b0, 32'h12345678);
    chk("mthi hi", 64'(bus.Hi), 64'h12345678);
    chk("mthi lo", 64'(bus.Lo), 64'd0);
    do_move(1'b1, 1'b1, 32'hCAFEF00D);
    chk("mthilo hi", 64'(bus.Hi), 64'hCAFEF00D);
    chk("mthilo lo", 64'(bus.Lo), 64'hCAFEF00D);

    do_op("mult",    2'b00, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0);
    do_op("multu",   2'b01, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 0);
    do_op("div neg", 2'b10, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
    do_op("divu",    2'b11, 32'd7,        32'd2,        32'd1,        32'd3,        1'b1, 0);
    do_op("div nb",  2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 0);
    do_op("div ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 0);
    do_op("divu z",  2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b0, 0);
    do_op("div z",   2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 0);
    do_op("busy ign",2'b01, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 5);

    // Reset in the middle of a DIVU aborts it.
    do_move(1'b1, 1'b1, 32'h11112222);
    bus.Op    = 2'b11;
    bus.inA   = 32'd1000;
    bus.inB   = 32'd3;
    bus.Start = 1'b1;
    @(posedge Clk);
    #1 bus.Start = 1'b0;
    repeat (9) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    chk("abort busy", 64'(bus.Busy), 64'd0);
    chk("abort hi",   64'(bus.Hi),   64'd0);
    chk("abort lo",   64'(bus.Lo),   64'd0);
    seen_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) seen_done = 1'b1;
    end
    chk("abort no done", 64'(seen_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
